// File: rtl/gate_vector_sequencer_if.sv
// Signal bundle between the gate-vector sequencer, its controller and the gate block under test.
// The master side issues start and returns the gate outputs; the slave side is the sequencer.
interface gate_vector_sequencer_if #(
  parameter int unsigned ERR_W = 4
);
  logic             start;
  logic             a;
  logic             b;
  logic             y_and;
  logic             y_or;
  logic             y_nand;
  logic             y_xor;
  logic             busy;
  logic [1:0]       vec_idx;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [15:0]      result;

  modport master (
    output start, y_and, y_or, y_nand, y_xor,
    input  a, b, busy, vec_idx, done, pass, err_count, result
  );

  modport slave (
    input  start, y_and, y_or, y_nand, y_xor,
    output a, b, busy, vec_idx, done, pass, err_count, result
  );
endinterface

// File: rtl/gate_vector_sequencer.sv
// On-chip self-test of the AND/OR/NAND/XOR gate block: walks a/b through all four vectors,
// captures the gate outputs after a programmable hold and checks them against the truth table.
module gate_vector_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ERR_W       = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  gate_vector_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  // Expected {xor,nand,or,and} nibble per vector index {a,b}.
  localparam logic [15:0]      ExpNibbles = 16'h3EE4;
  localparam logic [7:0]       HoldLast   = 8'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ErrMax     = '1;

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [1:0]       vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      result_q, result_d;
  logic [3:0]       sampled;

  assign sampled = {bus.y_xor, bus.y_nand, bus.y_or, bus.y_and};

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    vec_d    = vec_q;
    pass_d   = pass_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StDrive;
          hold_d   = '0;
          vec_d    = '0;
          err_d    = '0;
          result_d = '0;
          pass_d   = 1'b0;
        end
      end
      StDrive: begin
        if (hold_q == HoldLast) begin
          hold_d = '0;
          result_d[{vec_q, 2'b00} +: 4] = sampled;
          // One count per mismatching vector, regardless of how many bits differ.
          if ((sampled != ExpNibbles[{vec_q, 2'b00} +: 4]) && (err_q != ErrMax)) begin
            err_d = err_q + 1'b1;
          end
          if (vec_q == 2'd3) begin
            state_d = StDone;
            vec_d   = '0;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StDrive);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign bus.a         = vec_q[1];
  assign bus.b         = vec_q[0];
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboard bench for gate_vector_sequencer: two instances (hold 4 / 4-bit errors and
// hold 1 / 1-bit errors) driven by a gate-block model with injectable per-vector faults.
module tb_gate_vector_sequencer;

  typedef struct packed {
    int unsigned k;
    logic [15:0] res;
    logic [3:0]  err;
    logic        pss;
  } exp_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [1:0]  vec;
    logic        a;
    logic        b;
    logic [15:0] res;
    logic [3:0]  err;
    logic        pss;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] mask [2];
  obs_t        obs [2];

  int          errors;
  int          checks;
  int unsigned edges;
  int unsigned cur_k [2];
  int unsigned next_free [2];
  bit          have_run [2];
  logic [15:0] last_res [2];
  logic [3:0]  last_err [2];
  logic        last_pss [2];
  bit          end_req;
  bit          end_seen;
  exp_t        sb0 [$];
  exp_t        sb1 [$];

  gate_vector_sequencer_if #(.ERR_W(4)) if0 ();
  gate_vector_sequencer_if #(.ERR_W(1)) if1 ();

  gate_vector_sequencer #(.HOLD_CYCLES(4), .ERR_W(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  gate_vector_sequencer #(.HOLD_CYCLES(1), .ERR_W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gate_ref(input logic a, input logic b);
    return {a ^ b, ~(a & b), a | b, a & b};
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] idx);
    return 4'(w >> (4 * idx));
  endfunction

  function automatic int unsigned hold_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int unsigned sat_of(input int i);
    return (i == 0) ? 15 : 1;
  endfunction

  // Expected outcome of a whole run from the fault mask: result is the faulty truth table,
  // errors are the number of faulted vectors clipped at the counter maximum.
  function automatic exp_t model_run(input int i, input logic [15:0] m, input int unsigned k);
    exp_t        e;
    int unsigned cnt;
    logic [1:0]  v;
    cnt   = 0;
    e     = '0;
    e.k   = k;
    for (int j = 0; j < 4; j++) begin
      v = 2'(j);
      e.res = e.res | (16'(gate_ref(v[1], v[0]) ^ nib(m, v)) << (4 * j));
      if (nib(m, v) != 4'h0) cnt++;
    end
    e.err = 4'((cnt > sat_of(i)) ? sat_of(i) : cnt);
    e.pss = (cnt == 0);
    return e;
  endfunction

  always_comb begin
    {if0.y_xor, if0.y_nand, if0.y_or, if0.y_and} =
        gate_ref(if0.a, if0.b) ^ nib(mask[0], {if0.a, if0.b});
    {if1.y_xor, if1.y_nand, if1.y_or, if1.y_and} =
        gate_ref(if1.a, if1.b) ^ nib(mask[1], {if1.a, if1.b});
  end

  assign if0.start = start;
  assign if1.start = start;

  always_comb begin
    obs[0] = '0;
    obs[1] = '0;
    obs[0].busy = if0.busy;
    obs[0].done = if0.done;
    obs[0].vec  = if0.vec_idx;
    obs[0].a    = if0.a;
    obs[0].b    = if0.b;
    obs[0].res  = if0.result;
    obs[0].err  = 4'(if0.err_count);
    obs[0].pss  = if0.pass;
    obs[1].busy = if1.busy;
    obs[1].done = if1.done;
    obs[1].vec  = if1.vec_idx;
    obs[1].a    = if1.a;
    obs[1].b    = if1.b;
    obs[1].res  = if1.result;
    obs[1].err  = 4'(if1.err_count);
    obs[1].pss  = if1.pass;
  end

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d edge=%0d: got %h, expected %h", name, i, edges, act, req);
    end
  endtask

  // Reference model: decides from start and run lengths when each instance accepts a run,
  // and pushes the expected outcome onto that instance's scoreboard.
  initial begin
    edges = 0;
    for (int i = 0; i < 2; i++) begin
      have_run[i]  = 1'b0;
      next_free[i] = 0;
      cur_k[i]     = 0;
    end
    forever begin
      @(posedge clk);
      edges++;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          have_run[i]  = 1'b0;
          next_free[i] = 0;
          if (i == 0) sb0.delete();
          else        sb1.delete();
        end else if (start && (edges >= next_free[i])) begin
          if (i == 0) sb0.push_back(model_run(i, mask[i], edges));
          else        sb1.push_back(model_run(i, mask[i], edges));
          cur_k[i]     = edges;
          have_run[i]  = 1'b1;
          next_free[i] = edges + 4 * hold_of(i) + 2;
        end
      end
    end
  end

  // Monitor: per-cycle control checks, scoreboard pop on done, retention checks in idle.
  initial begin
    int unsigned n;
    int unsigned h;
    bit          e_busy;
    bit          e_done;
    logic [1:0]  e_vec;
    exp_t        e;
    bit          got;
    end_seen = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        for (int i = 0; i < 2; i++) begin
          chk("reset_outputs", i, 32'(obs[i]), 32'h0);
          last_res[i] = '0;
          last_err[i] = '0;
          last_pss[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          h      = hold_of(i);
          n      = edges - cur_k[i];
          e_busy = have_run[i] && (n < 4 * h);
          e_done = have_run[i] && (n == 4 * h);
          e_vec  = e_busy ? 2'(n / h) : 2'd0;
          chk("ctl_busy_done_vec_ab", i,
              32'({obs[i].busy, obs[i].done, obs[i].vec, obs[i].a, obs[i].b}),
              32'({e_busy, e_done, e_vec, e_vec}));
          if (obs[i].done === 1'b1) begin
            got = 1'b0;
            if (i == 0 && sb0.size() != 0) begin
              e = sb0.pop_front(); got = 1'b1;
            end else if (i == 1 && sb1.size() != 0) begin
              e = sb1.pop_front(); got = 1'b1;
            end
            if (!got) begin
              chk("done_without_run", i, 32'd1, 32'd0);
            end else begin
              chk("done_latency", i, edges - e.k, 4 * h);
              chk("run_result", i, 32'(obs[i].res), 32'(e.res));
              chk("run_err_pass", i, 32'({obs[i].err, obs[i].pss}), 32'({e.err, e.pss}));
              last_res[i] = e.res;
              last_err[i] = e.err;
              last_pss[i] = e.pss;
            end
          end else if (!e_busy && !e_done) begin
            chk("idle_retention", i, 32'({obs[i].res, obs[i].err, obs[i].pss}),
                32'({last_res[i], last_err[i], last_pss[i]}));
          end
        end
        if (end_req && !end_seen) begin
          chk("scoreboard_drained", 0, 32'(sb0.size()), 32'd0);
          chk("scoreboard_drained", 1, 32'(sb1.size()), 32'd0);
          end_seen = 1'b1;
        end
      end
    end
  end

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    m = '0;
    for (int j = 0; j < 4; j++) begin
      if ($urandom_range(0, 1) == 1) m = m | (16'($urandom_range(1, 15)) << (4 * j));
    end
    return m;
  endfunction

  task automatic quiet();
    repeat (24) @(posedge clk);
  endtask

  // One start pulse; optionally retrigger while dut0 is driving and while it is in DONE.
  task automatic run(input logic [15:0] m0, input logic [15:0] m1, input bit extras);
    @(posedge clk);
    #2;
    mask[0] = m0;
    mask[1] = m1;
    start   = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    if (extras) begin
      repeat (6) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (9) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
    end
    quiet();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    end_req = 1'b0;
    rst_n   = 1'b0;
    start   = 1'b0;
    mask[0] = '0;
    mask[1] = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    quiet();

    run(16'h0000, 16'h0000, 1'b0);  // healthy gate block
    run(16'h0880, 16'h0880, 1'b0);  // y_xor stuck at 0
    run(16'hC11B, 16'hC11B, 1'b0);  // every output stuck at 1
    run(16'h0000, 16'h0000, 1'b1);  // retriggers in DRIVE and DONE

    // Start held high: back-to-back runs.
    @(posedge clk);
    #2;
    mask[0] = 16'h0000;
    mask[1] = 16'h0100;
    start   = 1'b1;
    repeat (60) @(posedge clk);
    #2 start = 1'b0;
    quiet();

    // Asynchronous reset in the middle of dut0's third vector.
    @(posedge clk);
    #2;
    mask[0] = 16'h0000;
    mask[1] = 16'h0000;
    start   = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    quiet();
    run(16'h0000, 16'h0000, 1'b0);

    for (int r = 0; r < 24; r++) begin
      run(rand_mask(), rand_mask(), 1'($urandom_range(0, 1)));
    end

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
